range_counter: RTL and testbench

- Parametrised bounded counter replacing fixed-range wrap counters (e.g. 1..500) used for spawn positions, sprite timing and pseudo-random selection in the game logic.
- Counts within [MIN_VAL, MAX_VAL] with a built-in prescaler and run-time selectable mode: up-wrap, down-wrap, ping-pong, one-shot.
- Adds load, clear, enable, a wrap/turn pulse and a done flag.
- Sits beside the game FSM and the VGA object logic; all outputs are registered.

---
 rtl/range_counter_pkg.sv | 14 +
 rtl/range_counter_if.sv | 26 ++
 rtl/tick_prescaler.sv | 36 +++
 rtl/range_counter.sv | 128 ++++++++++++
 tb/tb_range_counter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/range_counter_pkg.sv
// Shared encodings for the bounded range counter: count modes and direction values.
package range_counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP_WRAP   = 2'd0,
        MODE_DOWN_WRAP = 2'd1,
        MODE_BOUNCE    = 2'd2,
        MODE_ONE_SHOT  = 2'd3
    } mode_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/range_counter_if.sv
// Control/status bundle between a game-logic client (master) and a range_counter (slave).
interface range_counter_if
    import range_counter_pkg::*;
#(
    parameter int WIDTH = 10
);
    logic             en;
    mode_t            mode;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             wrap;
    logic             done;

    modport master (
        output en, mode, clear, load, load_val,
        input  count, dir, wrap, done
    );

    modport slave (
        input  en, mode, clear, load, load_val,
        output count, dir, wrap, done
    );
endinterface

// File: rtl/tick_prescaler.sv
// Divides an enable into a one-cycle tick every PRESCALE enabled cycles; restart rephases it.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic tick
);
    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    if (PRESCALE < 1) begin : g_bad_prescale
        $fatal(1, "tick_prescaler: PRESCALE must be >= 1");
    end

    logic [PW-1:0] pre_q, pre_d;

    assign tick = en && (pre_q == LAST);

    always_comb begin
        pre_d = pre_q;
        if (restart)
            pre_d = '0;
        else if (en)
            pre_d = (pre_q == LAST) ? '0 : pre_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre_q <= '0;
        else
            pre_q <= pre_d;
    end
endmodule

// File: rtl/range_counter.sv
// Bounded counter over [MIN_VAL, MAX_VAL] with prescaler and up/down/bounce/one-shot modes.
// All outputs come straight from flops; next-value math is one bit wider than count.
module range_counter
    import range_counter_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int MIN_VAL  = 1,
    parameter int MAX_VAL  = 500,
    parameter int PRESCALE = 1
) (
    input logic            clk,
    input logic            rst_n,
    range_counter_if.slave bus
);
    localparam logic [WIDTH:0] MIN_X = (WIDTH + 1)'(MIN_VAL);
    localparam logic [WIDTH:0] MAX_X = (WIDTH + 1)'(MAX_VAL);

    if (MIN_VAL < 0 || MIN_VAL > MAX_VAL) begin : g_bad_range
        $fatal(1, "range_counter: need 0 <= MIN_VAL <= MAX_VAL");
    end
    if ((MAX_VAL >> WIDTH) != 0) begin : g_bad_width
        $fatal(1, "range_counter: MAX_VAL does not fit in WIDTH bits");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             tick;
    logic [WIDTH:0]   cnt_x, inc_x, dec_x, lv_x, ld_x;

    tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (bus.en),
        .restart (bus.clear | bus.load),
        .tick    (tick)
    );

    assign cnt_x = {1'b0, count_q};
    assign inc_x = cnt_x + 1'b1;
    assign dec_x = cnt_x - 1'b1;
    assign lv_x  = {1'b0, bus.load_val};
    assign ld_x  = (lv_x < MIN_X) ? MIN_X : ((lv_x > MAX_X) ? MAX_X : lv_x);

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        done_d  = (bus.mode == MODE_ONE_SHOT) ? done_q : 1'b0;
        wrap_d  = 1'b0;
        if (bus.clear) begin
            count_d = (bus.mode == MODE_DOWN_WRAP) ? MAX_X[WIDTH-1:0] : MIN_X[WIDTH-1:0];
            dir_d   = (bus.mode == MODE_DOWN_WRAP) ? DIR_DOWN : DIR_UP;
            done_d  = 1'b0;
        end else if (bus.load) begin
            count_d = ld_x[WIDTH-1:0];
            done_d  = 1'b0;
            if (bus.mode == MODE_DOWN_WRAP || (bus.mode == MODE_BOUNCE && ld_x == MAX_X))
                dir_d = DIR_DOWN;
            else
                dir_d = DIR_UP;
        end else if (tick) begin
            unique case (bus.mode)
                MODE_UP_WRAP: begin
                    wrap_d  = (cnt_x == MAX_X);
                    count_d = wrap_d ? MIN_X[WIDTH-1:0] : inc_x[WIDTH-1:0];
                end
                MODE_DOWN_WRAP: begin
                    wrap_d  = (cnt_x == MIN_X);
                    count_d = wrap_d ? MAX_X[WIDTH-1:0] : dec_x[WIDTH-1:0];
                end
                MODE_BOUNCE: begin
                    if (MIN_VAL == MAX_VAL) begin
                        dir_d  = ~dir_q;
                        wrap_d = 1'b1;
                    end else if (dir_q == DIR_UP) begin
                        if (cnt_x >= MAX_X) begin
                            count_d = dec_x[WIDTH-1:0];
                            dir_d   = DIR_DOWN;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = inc_x[WIDTH-1:0];
                        end
                    end else begin
                        if (cnt_x <= MIN_X) begin
                            count_d = inc_x[WIDTH-1:0];
                            dir_d   = DIR_UP;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = dec_x[WIDTH-1:0];
                        end
                    end
                end
                MODE_ONE_SHOT: begin
                    // Completion fires once, whether we step onto MAX or were parked there.
                    if (!done_q) begin
                        if (cnt_x < MAX_X)
                            count_d = inc_x[WIDTH-1:0];
                        if (cnt_x >= MAX_X || inc_x == MAX_X) begin
                            done_d = 1'b1;
                            wrap_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= MIN_X[WIDTH-1:0];
            dir_q   <= DIR_UP;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.dir   = dir_q;
    assign bus.wrap  = wrap_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_range_counter.sv
// Four counter instances (default, prescaled, tiny bounce range, degenerate range) share one
// stimulus stream; a behavioural model queues expected outputs and a monitor compares them.
module tb_range_counter;
    import range_counter_pkg::*;

    localparam int N = 4;

    function automatic int pmin(int g);
        case (g) 3: return 7; default: return 1; endcase
    endfunction
    function automatic int pmax(int g);
        case (g) 2: return 4; 3: return 7; default: return 500; endcase
    endfunction
    function automatic int ppre(int g);
        return (g == 1) ? 4 : 1;
    endfunction

    typedef struct packed {
        logic [N-1:0][9:0] cnt;
        logic [N-1:0]      dir;
        logic [N-1:0]      wrap;
        logic [N-1:0]      done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, clear = 1'b0, load = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [9:0] lv = '0;
    logic [N-1:0][9:0] cnt_o;
    logic [N-1:0] dir_o, wrap_o, done_o;

    int checks = 0, errors = 0;
    exp_t sb_q[$];
    int m_cnt[N], m_dir[N], m_done[N], m_pre[N], m_wrap[N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        range_counter_if #(.WIDTH(10)) ifc ();
        assign ifc.en       = en;
        assign ifc.mode     = mode_t'(mode);
        assign ifc.clear    = clear;
        assign ifc.load     = load;
        assign ifc.load_val = lv;
        assign cnt_o[g]     = ifc.count;
        assign dir_o[g]     = ifc.dir;
        assign wrap_o[g]    = ifc.wrap;
        assign done_o[g]    = ifc.done;
        range_counter #(.WIDTH(10), .MIN_VAL(pmin(g)), .MAX_VAL(pmax(g)),
                        .PRESCALE(ppre(g))) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc.slave)
        );
    end

    task automatic chk(string name, int g, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0d expected %0d", name, g, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < N; g++) begin
            m_cnt[g] = pmin(g); m_dir[g] = 1; m_done[g] = 0; m_pre[g] = 0; m_wrap[g] = 0;
        end
    endtask

    // Reference behaviour: positions inside the range are handled with modular arithmetic.
    task automatic model_step(int g);
        int lo, hi, r, c;
        bit tick;
        lo = pmin(g); hi = pmax(g); r = hi - lo + 1;
        m_wrap[g] = 0;
        if (mode != 2'd3) m_done[g] = 0;
        if (clear) begin
            m_cnt[g] = (mode == 2'd1) ? hi : lo;
            m_dir[g] = (mode == 2'd1) ? 0 : 1;
            m_done[g] = 0; m_pre[g] = 0;
        end else if (load) begin
            c = (lv < lo) ? lo : ((lv > hi) ? hi : int'(lv));
            m_cnt[g] = c;
            m_dir[g] = (mode == 2'd1 || (mode == 2'd2 && c == hi)) ? 0 : 1;
            m_done[g] = 0; m_pre[g] = 0;
        end else begin
            tick = en && (m_pre[g] == ppre(g) - 1);
            if (en) m_pre[g] = (m_pre[g] + 1) % ppre(g);
            if (tick) begin
                case (mode)
                    2'd0: begin
                        m_cnt[g] = lo + (m_cnt[g] - lo + 1) % r;
                        m_wrap[g] = (m_cnt[g] == lo);
                    end
                    2'd1: begin
                        m_cnt[g] = lo + (m_cnt[g] - lo - 1 + r) % r;
                        m_wrap[g] = (m_cnt[g] == hi);
                    end
                    2'd2: begin
                        m_wrap[g] = 0;
                        if (r == 1) begin
                            m_dir[g] = !m_dir[g]; m_wrap[g] = 1;
                        end else begin
                            c = m_cnt[g] + (m_dir[g] ? 1 : -1);
                            if (c > hi || c < lo) begin
                                m_dir[g] = !m_dir[g];
                                c = m_cnt[g] + (m_dir[g] ? 1 : -1);
                                m_wrap[g] = 1;
                            end
                            m_cnt[g] = c;
                        end
                    end
                    default: begin
                        if (!m_done[g]) begin
                            if (m_cnt[g] < hi) m_cnt[g]++;
                            if (m_cnt[g] == hi) begin m_done[g] = 1; m_wrap[g] = 1; end
                        end
                    end
                endcase
            end
        end
    endtask

    // Called at a falling edge; applies inputs for the next rising edge.
    task automatic drive(bit e, bit [1:0] md, bit cl, bit ld, bit [9:0] v);
        exp_t x;
        en = e; mode = md; clear = cl; load = ld; lv = v;
        for (int g = 0; g < N; g++) begin
            model_step(g);
            x.cnt[g] = 10'(m_cnt[g]); x.dir[g] = 1'(m_dir[g]);
            x.wrap[g] = 1'(m_wrap[g]); x.done[g] = 1'(m_done[g]);
        end
        sb_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic run(int n, bit [1:0] md);
        for (int i = 0; i < n; i++) drive(1'b1, md, 1'b0, 1'b0, 10'd0);
    endtask

    task automatic check_reset_state(string name);
        for (int g = 0; g < N; g++) begin
            chk({name, "_count"}, g, int'(cnt_o[g]), pmin(g));
            chk({name, "_dir"},   g, int'(dir_o[g]), 1);
            chk({name, "_wrap"},  g, int'(wrap_o[g]), 0);
            chk({name, "_done"},  g, int'(done_o[g]), 0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int g = 0; g < N; g++) begin
                    chk("count", g, int'(cnt_o[g]), int'(e.cnt[g]));
                    chk("dir",   g, int'(dir_o[g]), int'(e.dir[g]));
                    chk("wrap",  g, int'(wrap_o[g]), int'(e.wrap[g]));
                    chk("done",  g, int'(done_o[g]), int'(e.done[g]));
                end
            end
        end
    end

    initial begin : stim
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        // Up-wrap through the full range and past the wrap point.
        run(502, 2'd0);
        // Asynchronous reset mid-cycle must act without a clock edge.
        #2 rst_n = 1'b0;
        #1 check_reset_state("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        // Prescaler phase with an enable gap.
        run(6, 2'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 2'd0, 1'b0, 1'b0, 10'd0);
        run(9, 2'd0);
        // Down-wrap from clear, through the low boundary.
        drive(1'b0, 2'd1, 1'b1, 1'b0, 10'd0);
        run(505, 2'd1);
        // Bounce from clear.
        drive(1'b0, 2'd2, 1'b1, 1'b0, 10'd0);
        run(20, 2'd2);
        // One-shot completion, hold, then clear.
        drive(1'b0, 2'd3, 1'b0, 1'b1, 10'd498);
        run(12, 2'd3);
        drive(1'b1, 2'd3, 1'b1, 1'b0, 10'd0);
        run(3, 2'd3);
        // Load clamp and priority cases.
        drive(1'b1, 2'd0, 1'b0, 1'b1, 10'd0);
        drive(1'b1, 2'd0, 1'b0, 1'b1, 10'd900);
        drive(1'b1, 2'd0, 1'b1, 1'b1, 10'd250);
        drive(1'b1, 2'd2, 1'b0, 1'b1, 10'd4);
        run(4, 2'd2);
        drive(1'b1, 2'd3, 1'b0, 1'b1, 10'd500);
        run(3, 2'd3);
        // Randomised mix including mode changes mid-run.
        for (int i = 0; i < 4000; i++) begin
            bit e, cl, ld;
            e  = ($urandom_range(0, 9) != 0);
            cl = ($urandom_range(0, 99) == 0);
            ld = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            drive(e, mode, cl, ld,
                  ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 1023))
                                              : 10'($urandom_range(0, 9)));
        end
        @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
